// File: rtl/stream_pack.sv
// stream_pack: narrow-to-wide stream packer.
// Consecutive IW-bit beats are packed LSB-lane first into N-lane words with a
// per-lane keep mask. Up to two words are held: one in the output register and
// one in the accumulator. All outputs are registered.
// Optional feature: define STREAM_PACK_TIMEOUT_EN to flush a partially filled
// word after TIMEOUT idle cycles. Without it, partial words wait for completion.
module stream_pack #(
   parameter int IW      = 8,
   parameter int N       = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rstn,
   output logic            i_rdy,
   input  logic            i_en,
   input  logic [IW-1:0]   i_data,
   input  logic            o_rdy,
   output logic            o_en,
   output logic [IW*N-1:0] o_data,
   output logic [N-1:0]    o_keep
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_LANE_C = CW'(N - 1);

   typedef logic [N-1:0][IW-1:0] word_t;

   // Elaboration-time parameter legality checks
   if ((N < 2) || (N > 16)) begin : g_bad_n
      $error("stream_pack: N must be within 2..16");
   end
   if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_bad_timeout
      $error("stream_pack: TIMEOUT must be within 2..65535");
   end

   word_t           acc_r;
   word_t           acc_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_s;
   logic            acc_full_r;
   logic            acc_full_s;
   word_t           done_word_s;
   word_t           o_word_s;
   logic [N-1:0]    o_keep_s;
   logic            o_en_s;
   logic            accept_s;
   logic            consume_s;
   logic            out_free_s;
   logic            flush_s;

   assign accept_s   = i_en & i_rdy;
   assign consume_s  = o_en & o_rdy;
   assign out_free_s = ~o_en | o_rdy;

`ifdef STREAM_PACK_TIMEOUT_EN
   localparam logic [15:0] TMO_C = 16'(TIMEOUT);

   logic [15:0]  idle_r;
   logic [15:0]  idle_s;
   word_t        part_keep_word_unused_s;
   logic [N-1:0] part_keep_s;

   assign part_keep_word_unused_s = '0;

   // Keep mask of a partial word: lanes below the current fill count
   always_comb begin
      part_keep_s = {N{1'b0}};
      for (int k = 0; k < N; k++) begin
         if (k < int'(cnt_r)) begin
            part_keep_s[k] = 1'b1;
         end else begin
            part_keep_s[k] = 1'b0;
         end
      end
   end

   // Idle counter: runs only while a partial word sits waiting, saturates
   always_comb begin
      idle_s = idle_r;
      if (accept_s || (cnt_r == {CW{1'b0}})) begin
         idle_s = 16'd0;
      end else if (!acc_full_r && (idle_r != TMO_C)) begin
         idle_s = idle_r + 16'd1;
      end else begin
         idle_s = idle_r;
      end
   end

   // A non-empty partial word is flushed once idle long enough and the output is free
   assign flush_s = (idle_r == TMO_C) && (cnt_r != {CW{1'b0}}) && !accept_s && out_free_s;

   // Idle counter register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idle_r <= 16'd0;
      end else begin
         idle_r <= idle_s;
      end
   end
`else
   assign flush_s = 1'b0;
`endif

   // Accumulator contents with the incoming beat dropped into the current lane
   always_comb begin
      done_word_s        = acc_r;
      done_word_s[cnt_r] = i_data;
   end

   // Next-state logic: drain pending word, else take a beat, else flush on timeout
   always_comb begin
      acc_s      = acc_r;
      cnt_s      = cnt_r;
      acc_full_s = acc_full_r;
      o_word_s   = o_data;
      o_keep_s   = o_keep;
      if (consume_s) begin
         o_en_s = 1'b0;
      end else begin
         o_en_s = o_en;
      end

      if (acc_full_r && out_free_s) begin
         o_word_s   = acc_r;
         o_keep_s   = {N{1'b1}};
         o_en_s     = 1'b1;
         acc_full_s = 1'b0;
         cnt_s      = {CW{1'b0}};
         acc_s      = '0;
      end else if (accept_s) begin
         if (cnt_r != LAST_LANE_C) begin
            acc_s = done_word_s;
            cnt_s = cnt_r + CW'(1);
         end else if (out_free_s) begin
            // Last lane with a free output: bypass the accumulator
            o_word_s = done_word_s;
            o_keep_s = {N{1'b1}};
            o_en_s   = 1'b1;
            cnt_s    = {CW{1'b0}};
            acc_s    = '0;
         end else begin
            acc_s      = done_word_s;
            acc_full_s = 1'b1;
         end
      end else if (flush_s) begin
`ifdef STREAM_PACK_TIMEOUT_EN
         o_keep_s = part_keep_s;
`else
         o_keep_s = {N{1'b1}};
`endif
         o_word_s = acc_r;
         o_en_s   = 1'b1;
         cnt_s    = {CW{1'b0}};
         acc_s    = '0;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_r      <= '0;
         cnt_r      <= {CW{1'b0}};
         acc_full_r <= 1'b0;
         i_rdy      <= 1'b1;
         o_en       <= 1'b0;
         o_data     <= {(IW*N){1'b0}};
         o_keep     <= {N{1'b0}};
      end else begin
         acc_r      <= acc_s;
         cnt_r      <= cnt_s;
         acc_full_r <= acc_full_s;
         i_rdy      <= ~acc_full_s;
         o_en       <= o_en_s;
         o_data     <= o_word_s;
         o_keep     <= o_keep_s;
      end
   end

endmodule

// File: tb/tb_stream_pack.sv
// Testbench for stream_pack (IW=8, N=4, TIMEOUT=16). Directed scenarios plus a
// randomized run; every consumed word is checked against a byte-queue model.
module tb_stream_pack;

   localparam int IW  = 8;
   localparam int N   = 4;
   localparam int TMO = 16;

   logic          clk    = 1'b0;
   logic          rstn   = 1'b0;
   logic          i_rdy;
   logic          i_en   = 1'b0;
   logic [7:0]    i_data = 8'h00;
   logic          o_rdy  = 1'b0;
   logic          o_en;
   logic [31:0]   o_data;
   logic [3:0]    o_keep;

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [7:0]    in_q[$];
   logic          prev_stall = 1'b0;
   logic [31:0]   prev_data  = 32'h0;
   logic [3:0]    prev_keep  = 4'h0;
   logic          last_acc   = 1'b0;

   stream_pack #(.IW(IW), .N(N), .TIMEOUT(TMO)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .i_rdy  (i_rdy),
      .i_en   (i_en),
      .i_data (i_data),
      .o_rdy  (o_rdy),
      .o_en   (o_en),
      .o_data (o_data),
      .o_keep (o_keep)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Compare the word being consumed with the oldest accepted bytes
   task automatic check_word();
      logic [31:0] exp;
      int          nl;
      exp = 32'h0;
      nl  = $countones(o_keep);
`ifdef STREAM_PACK_TIMEOUT_EN
      chk_eq("keep_shape", ((o_keep & (o_keep + 4'd1)) == 4'd0) && (o_keep != 4'd0), 1);
`else
      chk_eq("keep_full", o_keep, 4'hF);
`endif
      chk_eq("sb_bytes_avail", in_q.size() >= nl, 1);
      for (int k = 0; k < nl; k++) begin
         if (in_q.size() > 0) exp[k*8 +: 8] = in_q.pop_front();
      end
      chk_eq("sb_word", o_data, exp);
   endtask

   // One clock: drive at negedge, observe handshakes, return just after posedge
   task automatic tick(input logic en, input logic [7:0] d, input logic rdy);
      @(negedge clk);
      i_en   = en;
      i_data = d;
      o_rdy  = rdy;
      #1;
      if (prev_stall) begin
         chk_eq("stall_en",   o_en,   1);
         chk_eq("stall_data", o_data, prev_data);
         chk_eq("stall_keep", o_keep, prev_keep);
      end
      last_acc = i_en && i_rdy;
      if (last_acc) in_q.push_back(i_data);
      if (o_en && o_rdy) check_word();
      prev_stall = o_en && !o_rdy;
      prev_data  = o_data;
      prev_keep  = o_keep;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      i_en = 1'b0;
      o_rdy = 1'b0;
      #1;
      chk_eq("rst_o_en",   o_en,   0);
      chk_eq("rst_o_keep", o_keep, 0);
      chk_eq("rst_o_data", o_data, 0);
      chk_eq("rst_i_rdy",  i_rdy,  1);
      in_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Watchdog
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b;
      int n;
      int acc;
      logic seen;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk_eq("init_o_en",   o_en,   0);
      chk_eq("init_o_data", o_data, 0);
      chk_eq("init_o_keep", o_keep, 0);
      chk_eq("init_i_rdy",  i_rdy,  1);
      @(negedge clk);
      rstn = 1'b1;

      // 1: full-rate streaming
      for (int k = 1; k <= 8; k++) begin
         tick(1'b1, 8'(k), 1'b1);
         chk_eq("t1_i_rdy", i_rdy, 1);
         if (k == 4) begin
            chk_eq("t1_en_w0",   o_en,   1);
            chk_eq("t1_data_w0", o_data, 32'h04030201);
            chk_eq("t1_keep_w0", o_keep, 4'hF);
         end
         if (k == 5) chk_eq("t1_en_drop", o_en, 0);
         if (k == 8) begin
            chk_eq("t1_en_w1",   o_en,   1);
            chk_eq("t1_data_w1", o_data, 32'h08070605);
            chk_eq("t1_keep_w1", o_keep, 4'hF);
         end
      end
      tick(1'b0, 8'h00, 1'b1);

      // 2: backpressure, two words held
      do_reset();
      b = 1;
      for (int c = 0; c < 20; c++) begin
         tick(1'b1, 8'(b), 1'b0);
         if (last_acc) b++;
      end
      chk_eq("t2_accepted", b - 1, 8);
      chk_eq("t2_i_rdy_lo", i_rdy, 0);
      chk_eq("t2_en",       o_en,  1);
      chk_eq("t2_data_w0",  o_data, 32'h04030201);
      tick(1'b1, 8'h09, 1'b1);
      chk_eq("t2_held_9",   last_acc, 0);
      chk_eq("t2_data_w1",  o_data, 32'h08070605);
      chk_eq("t2_en_w1",    o_en,   1);
      chk_eq("t2_i_rdy_hi", i_rdy,  1);
      tick(1'b1, 8'h09, 1'b1);
      chk_eq("t2_acc_9",    last_acc, 1);
      chk_eq("t2_en_drop",  o_en, 0);

`ifdef STREAM_PACK_TIMEOUT_EN
      // 3: idle flush of a partial word
      do_reset();
      tick(1'b1, 8'hAA, 1'b1);
      tick(1'b1, 8'hBB, 1'b1);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         tick(1'b0, 8'h00, 1'b1);
         if (o_en) begin
            n = c;
            break;
         end
      end
      chk_eq("t3_flush_lat", n, TMO + 1);
      chk_eq("t3_data", o_data, 32'h0000BBAA);
      chk_eq("t3_keep", o_keep, 4'h3);
      tick(1'b0, 8'h00, 1'b1);
`else
      // 4: no flush without the timeout feature
      do_reset();
      tick(1'b1, 8'hAA, 1'b1);
      tick(1'b1, 8'hBB, 1'b1);
      seen = 1'b0;
      repeat (1000) begin
         tick(1'b0, 8'h00, 1'b1);
         if (o_en) seen = 1'b1;
      end
      chk_eq("t4_no_flush", seen, 0);
      tick(1'b1, 8'hCC, 1'b1);
      tick(1'b1, 8'hDD, 1'b1);
      chk_eq("t4_en",   o_en,   1);
      chk_eq("t4_data", o_data, 32'hDDCCBBAA);
      chk_eq("t4_keep", o_keep, 4'hF);
      tick(1'b0, 8'h00, 1'b1);
`endif

      // 5: reset mid-word discards the partial word
      do_reset();
      for (int k = 1; k <= 3; k++) tick(1'b1, 8'(k), 1'b1);
      do_reset();
      for (int k = 1; k <= 4; k++) tick(1'b1, 8'(8'h10 + k), 1'b1);
      chk_eq("t5_en",   o_en,   1);
      chk_eq("t5_data", o_data, 32'h14131211);
      chk_eq("t5_keep", o_keep, 4'hF);
      tick(1'b0, 8'h00, 1'b1);

      // 6: random traffic against the byte scoreboard
      do_reset();
      acc = 0;
      for (int c = 0; c < 60000 && acc < 10000; c++) begin
         tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
         if (last_acc) acc++;
      end
      chk_eq("t6_accepted", acc, 10000);
      repeat (40) tick(1'b0, 8'h00, 1'b1);
      chk_eq("t6_drained",  in_q.size(), 0);
      chk_eq("t6_en_idle",  o_en, 0);
      chk_eq("t6_i_rdy",    i_rdy, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
